axi_read: RTL and testbench
===========================

// Module: axi_read
// PURPOSE
// - AXI-Lite read initiator shared by two requesters: maestro (priority) and fsm (low priority).
// - Arbitrates between them, issues one AR/R transaction at a time on axi_master and routes
//   read data and error status back to the granted requester.
// - Read-side companion of the AXI-Lite write initiator in the controls block.
// PARAMETERS
// - ADDR_W         32  AXI address width
// - DATA_W         32  AXI data width
// - FSM_STARVE_MAX  8  consecutive maestro grants with fsm_req_i pending before fsm is forced
// PORTS
// - seq_port.clk        in   1       clock (ADAM_SEQ.Slave seq_port)
// - seq_port.rst        in   1       reset, asynchronous, active-low
// - axi_master          AXI_LITE.Master  ar_addr/ar_prot/ar_valid/ar_ready, r_data/r_resp/r_valid/r_ready
// - maestro_adress_i    in   ADDR_W  maestro read address, held while maestro_req_i high
// - maestro_req_i       in   1       maestro request, level, held until maestro_ack_o
// - maestro_ack_o       out  1       1-cycle pulse: maestro request captured
// - maestro_valid_o     out  1       1-cycle pulse: maestro_data_o/maestro_err_o valid
// - maestro_data_o      out  DATA_W  read data, held until next maestro completion
// - maestro_err_o       out  1       r_resp[1] of the completed read, held like data
// - fsm_adress_i/fsm_req_i/fsm_ack_o/fsm_valid_o/fsm_data_o/fsm_err_o  same, fsm side
// BEHAVIOUR
// - Clocking: one clock; reset is asynchronous and active-low.
// - Reset: state IDLE; ar_valid=0, r_ready=0, ar_addr=0, ar_prot=3'b000; all ack/valid/err=0;
//   data_o=0; starve counter=0; grant=maestro. Reset mid-transaction drops ar_valid immediately.
// - FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//   IDLE: if any req: pick grant, register ar_addr from granted port, ar_valid<=1,
//         pulse granted *_ack_o (same edge as ar_valid rises), go ADDR.
//   ADDR: hold ar_valid and ar_addr stable; on ar_valid&&ar_ready: ar_valid<=0, r_ready<=1, go DATA.
//   DATA: on r_valid&&r_ready: capture r_data into granted data_o, r_resp[1] into err_o,
//         r_ready<=0, pulse granted *_valid_o, go RESP.
//   RESP: one idle cycle, go IDLE (no grant in RESP).
// - Arbitration in IDLE: maestro wins unless fsm_req_i && starve==FSM_STARVE_MAX -> fsm wins.
//   starve +1 on each maestro grant with fsm_req_i high; clears on fsm grant or when fsm_req_i low
//   in IDLE; saturates at FSM_STARVE_MAX.
// - Ungranted port: ack/valid stay 0, data/err unchanged; request stays pending.
// - Min latency: req seen in IDLE cycle 0 -> ack+ar_valid cycle 1; ar_ready@1, r_valid@2
//   -> valid_o cycle 3. Max throughput: one read per 4 cycles.
// - r_valid arriving in IDLE/ADDR/RESP is ignored (r_ready=0). r_ready never high outside DATA.
// - Requester dropping req after ack does not affect the in-flight transaction.
// - SLVERR/DECERR: data still delivered, err_o=1; no retry.
// STRUCTURE
// - banzai_axi_pkg: typedef enum {IDLE,ADDR,DATA,RESP} rd_state_t; AXI_RESP_OKAY/SLVERR/DECERR.
// - One sub-module: axi_rd_arbiter (priority + starvation counter, outputs grant, grant_valid).
// TESTING
// - Single maestro read 0x1000, slave ar_ready=1, r_data=0xCAFE0001 OKAY -> ack@1, valid@3,
//   maestro_data_o=0xCAFE0001, err=0, fsm outputs untouched.
// - Both req same cycle, addrs 0x10/0x20 -> maestro granted first (ar_addr=0x10), fsm next
//   (ar_addr=0x20) after RESP; fsm_ack_o only on second grant.
// - maestro_req_i held high continuously with fsm_req_i high -> 8 maestro grants then 1 fsm grant.
// - ar_ready low for 5 cycles -> ar_valid held, ar_addr stable 5 cycles; r_valid delayed 3
//   cycles -> r_ready held, valid_o one cycle after R handshake.
// - r_resp=2'b10, r_data=0x0 on fsm read -> fsm_valid_o pulse, fsm_err_o=1, fsm_data_o=0.
// - Assert reset in DATA state -> ar_valid/r_ready/valid/ack=0 same cycle; after release, new
//   maestro read completes normally.

Source files
------------

// File: rtl/banzai_axi_pkg.sv
// Shared types and constants for the AXI-Lite read initiator and its arbiter.
package banzai_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } rd_state_t;

  typedef enum logic {
    GRANT_MAESTRO = 1'b0,
    GRANT_FSM     = 1'b1
  } grant_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are the two responses that report a failed read.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Fixed-priority arbiter between maestro and fsm with a starvation counter
// that forces an fsm grant after FSM_STARVE_MAX back-to-back maestro wins.
module axi_rd_arbiter
  import banzai_axi_pkg::*;
#(
  parameter int FSM_STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic maestro_req,
  input  logic fsm_req,
  output logic grant,
  output logic grant_valid
);

  localparam int CNT_W = $clog2(FSM_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(FSM_STARVE_MAX);

  logic [CNT_W-1:0] starve;
  logic             force_fsm;

  // Maestro wins by default; fsm wins when alone or once it has waited long enough.
  always_comb begin
    force_fsm   = fsm_req && (starve == STARVE_LIMIT);
    grant       = (force_fsm || !maestro_req) ? GRANT_FSM : GRANT_MAESTRO;
    grant_valid = arb_en && (maestro_req || fsm_req);
  end

  // Count maestro grants that passed over a pending fsm request, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (arb_en) begin
      if (!fsm_req) begin
        starve <= '0;
      end else if (grant == GRANT_FSM) begin
        starve <= '0;
      end else if (starve != STARVE_LIMIT) begin
        starve <= starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read.sv
// AXI-Lite read initiator shared by maestro (priority) and fsm requesters.
// One AR/R transaction in flight at a time; results are routed to the owner.
module axi_read
  import banzai_axi_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FSM_STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // AXI-Lite read channels
  output logic [ADDR_W-1:0] ar_addr,
  output logic [2:0]        ar_prot,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_valid,
  output logic              r_ready,
  // maestro requester
  input  logic [ADDR_W-1:0] maestro_adress_i,
  input  logic              maestro_req_i,
  output logic              maestro_ack_o,
  output logic              maestro_valid_o,
  output logic [DATA_W-1:0] maestro_data_o,
  output logic              maestro_err_o,
  // fsm requester
  input  logic [ADDR_W-1:0] fsm_adress_i,
  input  logic              fsm_req_i,
  output logic              fsm_ack_o,
  output logic              fsm_valid_o,
  output logic [DATA_W-1:0] fsm_data_o,
  output logic              fsm_err_o
);

  rd_state_t state;
  rd_state_t state_next;
  grant_t    owner;
  logic      grant;
  logic      grant_valid;
  logic      ar_hs;
  logic      r_hs;

  axi_rd_arbiter #(
    .FSM_STARVE_MAX (FSM_STARVE_MAX)
  ) u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (state == IDLE),
    .maestro_req (maestro_req_i),
    .fsm_req     (fsm_req_i),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign ar_prot = AXI_PROT_DEFAULT;
  assign ar_hs   = ar_valid && ar_ready;
  assign r_hs    = r_valid && r_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one address phase, one data phase, one turnaround cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ADDR;
      ADDR:    if (ar_hs)       state_next = DATA;
      DATA:    if (r_hs)        state_next = RESP;
      RESP:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // AXI handshake signals, owner tracking and the one-cycle ack/valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_valid        <= 1'b0;
      ar_addr         <= '0;
      r_ready         <= 1'b0;
      owner           <= GRANT_MAESTRO;
      maestro_ack_o   <= 1'b0;
      fsm_ack_o       <= 1'b0;
      maestro_valid_o <= 1'b0;
      fsm_valid_o     <= 1'b0;
    end else begin
      maestro_ack_o   <= 1'b0;
      fsm_ack_o       <= 1'b0;
      maestro_valid_o <= 1'b0;
      fsm_valid_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_t'(grant);
            ar_valid <= 1'b1;
            if (grant == GRANT_FSM) begin
              ar_addr   <= fsm_adress_i;
              fsm_ack_o <= 1'b1;
            end else begin
              ar_addr       <= maestro_adress_i;
              maestro_ack_o <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (ar_hs) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            r_ready <= 1'b0;
            if (owner == GRANT_FSM) begin
              fsm_valid_o <= 1'b1;
            end else begin
              maestro_valid_o <= 1'b1;
            end
          end
        end
        default: begin
          ar_valid <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Capture read data and error status into the owner's output registers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maestro_data_o <= '0;
      maestro_err_o  <= 1'b0;
      fsm_data_o     <= '0;
      fsm_err_o      <= 1'b0;
    end else if ((state == DATA) && r_hs) begin
      if (owner == GRANT_FSM) begin
        fsm_data_o <= r_data;
        fsm_err_o  <= resp_is_err(r_resp);
      end else begin
        maestro_data_o <= r_data;
        maestro_err_o  <= resp_is_err(r_resp);
      end
    end
  end

endmodule

// File: tb/tb_axi_read.sv
// Self-checking bench for axi_read: directed scenarios followed by randomized
// reads, checked against a transaction-level model of arbitration and results.
module tb_axi_read;

  localparam int STARVE = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] m_addr;
  logic        m_req;
  logic        m_ack;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] f_addr;
  logic        f_req;
  logic        f_ack;
  logic        f_valid;
  logic [31:0] f_data;
  logic        f_err;

  int          compared;
  int          mismatched;

  // reference model state
  int          starve_m;
  logic [31:0] exp_m_data;
  logic [31:0] exp_f_data;
  logic        exp_m_err;
  logic        exp_f_err;

  axi_read #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .FSM_STARVE_MAX (STARVE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ar_addr          (ar_addr),
    .ar_prot          (ar_prot),
    .ar_valid         (ar_valid),
    .ar_ready         (ar_ready),
    .r_data           (r_data),
    .r_resp           (r_resp),
    .r_valid          (r_valid),
    .r_ready          (r_ready),
    .maestro_adress_i (m_addr),
    .maestro_req_i    (m_req),
    .maestro_ack_o    (m_ack),
    .maestro_valid_o  (m_valid),
    .maestro_data_o   (m_data),
    .maestro_err_o    (m_err),
    .fsm_adress_i     (f_addr),
    .fsm_req_i        (f_req),
    .fsm_ack_o        (f_ack),
    .fsm_valid_o      (f_valid),
    .fsm_data_o       (f_data),
    .fsm_err_o        (f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester-side outputs that must hold the model values when nothing completes.
  task automatic check_held(input string tag);
    check_output({tag, " m_data"}, m_data, exp_m_data);
    check_output({tag, " m_err"},  32'(m_err), 32'(exp_m_err));
    check_output({tag, " f_data"}, f_data, exp_f_data);
    check_output({tag, " f_err"},  32'(f_err), 32'(exp_f_err));
  endtask

  // One complete read starting from an IDLE cycle with at least one request pending.
  task automatic serve_read(input int ar_dly, input int r_dly, input logic [31:0] rdata,
                            input logic [1:0] rresp, input bit m_keep, input bit f_keep,
                            output bit obs_fsm);
    bit          g_fsm;
    logic [31:0] exp_addr;
    g_fsm    = f_req && ((starve_m == STARVE) || !m_req);
    exp_addr = g_fsm ? f_addr : m_addr;
    if (g_fsm) starve_m = 0;
    else if (f_req) starve_m = (starve_m < STARVE) ? starve_m + 1 : STARVE;
    else starve_m = 0;

    tick;
    obs_fsm = f_ack;
    check_output("grant ar_valid", 32'(ar_valid), 32'd1);
    check_output("grant ar_addr",  ar_addr, exp_addr);
    check_output("grant m_ack",    32'(m_ack), 32'(!g_fsm));
    check_output("grant f_ack",    32'(f_ack), 32'(g_fsm));
    check_output("grant r_ready",  32'(r_ready), 32'd0);
    if (g_fsm && !f_keep) begin f_req = 1'b0; f_addr = $urandom; end
    if (!g_fsm && !m_keep) begin m_req = 1'b0; m_addr = $urandom; end

    for (int i = 0; i < ar_dly; i++) begin
      r_valid = 1'($urandom);
      r_data  = $urandom;
      r_resp  = 2'($urandom);
      tick;
      check_output("addr hold ar_valid", 32'(ar_valid), 32'd1);
      check_output("addr hold ar_addr",  ar_addr, exp_addr);
      check_output("addr r_ready",       32'(r_ready), 32'd0);
      check_output("addr acks",          32'({m_ack, f_ack}), 32'd0);
      check_output("addr valids",        32'({m_valid, f_valid}), 32'd0);
    end
    ar_ready = 1'b1;
    tick;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    check_output("data ar_valid", 32'(ar_valid), 32'd0);
    check_output("data r_ready",  32'(r_ready), 32'd1);
    check_held("data");

    for (int i = 0; i < r_dly; i++) begin
      tick;
      check_output("data hold r_ready", 32'(r_ready), 32'd1);
      check_output("data valids",       32'({m_valid, f_valid}), 32'd0);
    end
    r_valid = 1'b1;
    r_data  = rdata;
    r_resp  = rresp;
    tick;
    r_valid = 1'b0;
    r_data  = $urandom;
    if (g_fsm) begin exp_f_data = rdata; exp_f_err = rresp[1]; end
    else       begin exp_m_data = rdata; exp_m_err = rresp[1]; end
    check_output("resp m_valid", 32'(m_valid), 32'(!g_fsm));
    check_output("resp f_valid", 32'(f_valid), 32'(g_fsm));
    check_output("resp r_ready", 32'(r_ready), 32'd0);
    check_held("resp");

    tick;
    check_output("idle valids",   32'({m_valid, f_valid}), 32'd0);
    check_output("idle acks",     32'({m_ack, f_ack}), 32'd0);
    check_output("idle ar_valid", 32'(ar_valid), 32'd0);
    check_output("idle r_ready",  32'(r_ready), 32'd0);
  endtask

  initial begin
    bit obs;
    int m_grants;
    bit fsm_seen;

    compared = 0; mismatched = 0;
    starve_m = 0;
    exp_m_data = '0; exp_f_data = '0; exp_m_err = 1'b0; exp_f_err = 1'b0;
    rst_n = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    m_req = 1'b0; f_req = 1'b0; m_addr = '0; f_addr = '0;

    // reset state
    tick; tick;
    check_output("reset ar_valid", 32'(ar_valid), 32'd0);
    check_output("reset r_ready",  32'(r_ready), 32'd0);
    check_output("reset ar_addr",  ar_addr, 32'd0);
    check_output("reset ar_prot",  32'(ar_prot), 32'd0);
    check_output("reset acks",     32'({m_ack, f_ack}), 32'd0);
    check_output("reset valids",   32'({m_valid, f_valid}), 32'd0);
    check_held("reset");
    rst_n = 1'b1;
    tick;

    // single maestro read
    m_req = 1'b1; m_addr = 32'h0000_1000;
    serve_read(0, 0, 32'hCAFE_0001, 2'b00, 1'b0, 1'b0, obs);
    check_output("single m_data", m_data, 32'hCAFE_0001);

    // simultaneous requests: maestro first, then fsm
    m_req = 1'b1; m_addr = 32'h10; f_req = 1'b1; f_addr = 32'h20;
    serve_read(0, 0, 32'h1111_0010, 2'b00, 1'b0, 1'b1, obs);
    check_output("both first grant fsm", 32'(obs), 32'd0);
    serve_read(0, 0, 32'h2222_0020, 2'b00, 1'b0, 1'b0, obs);
    check_output("both second grant fsm", 32'(obs), 32'd1);

    // maestro held continuously against a pending fsm request
    m_req = 1'b1; m_addr = 32'h40; f_req = 1'b1; f_addr = 32'h80;
    m_grants = 0; fsm_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      serve_read(0, 0, $urandom, 2'b00, 1'b1, 1'b0, obs);
      if (obs) fsm_seen = 1'b1;
      else if (!fsm_seen) m_grants++;
    end
    check_output("starve maestro grants", 32'(m_grants), 32'd8);
    check_output("starve fsm granted",    32'(fsm_seen), 32'd1);
    m_req = 1'b0;
    starve_m = 0;
    tick;

    // slow slave: ar_ready 5 cycles late, r_valid 3 cycles late
    m_req = 1'b1; m_addr = 32'h0000_2000;
    serve_read(5, 3, 32'h5A5A_A5A5, 2'b00, 1'b0, 1'b0, obs);

    // fsm read with SLVERR
    f_req = 1'b1; f_addr = 32'h0000_3000;
    serve_read(0, 0, 32'h0, 2'b10, 1'b0, 1'b0, obs);
    check_output("slverr f_err",  32'(f_err), 32'd1);
    check_output("slverr f_data", f_data, 32'd0);

    // reset asserted in DATA
    m_req = 1'b1; m_addr = 32'h0000_4000;
    tick;
    m_req = 1'b0;
    ar_ready = 1'b1;
    tick;
    ar_ready = 1'b0;
    check_output("pre-reset r_ready", 32'(r_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_m_data = '0; exp_f_data = '0; exp_m_err = 1'b0; exp_f_err = 1'b0; starve_m = 0;
    check_output("midreset ar_valid", 32'(ar_valid), 32'd0);
    check_output("midreset r_ready",  32'(r_ready), 32'd0);
    check_output("midreset acks",     32'({m_ack, f_ack}), 32'd0);
    check_output("midreset valids",   32'({m_valid, f_valid}), 32'd0);
    check_held("midreset");
    tick;
    rst_n = 1'b1;
    m_req = 1'b1; m_addr = 32'h0000_5000;
    serve_read(0, 0, 32'h0BAD_F00D, 2'b00, 1'b0, 1'b0, obs);

    // randomized reads
    for (int n = 0; n < 40; n++) begin
      if (!m_req && !f_req) begin
        if ($urandom_range(3) == 0) begin
          starve_m = 0;
          tick;
        end
        case ($urandom_range(2))
          0: begin m_req = 1'b1; m_addr = $urandom; end
          1: begin f_req = 1'b1; f_addr = $urandom; end
          default: begin m_req = 1'b1; m_addr = $urandom; f_req = 1'b1; f_addr = $urandom; end
        endcase
      end else if ($urandom_range(1) == 1) begin
        if (!m_req) begin m_req = 1'b1; m_addr = $urandom; end
        if (!f_req) begin f_req = 1'b1; f_addr = $urandom; end
      end
      serve_read($urandom_range(3), $urandom_range(3), $urandom, 2'($urandom),
                 ($urandom_range(3) != 0), 1'b0, obs);
    end

    m_req = 1'b0; f_req = 1'b0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
